id_ex_stage_reg: RTL and testbench

ID/EX pipeline register that sits directly downstream of ControlUnit and the register-file read in decode. It latches the decoded control bundle (MemReadEn, MemToReg, MemWriteEn, ALUSrc, RegWrite, BEQ, BNE, JALen, JALRen, ALUop) together with operands for the execute stage. It also contains the load-use hazard detector, which inserts a bubble and stalls upstream. Branch/jump resolution in EX can flush it.

---
 rtl/id_ex_stage_reg_if.sv | 74 +++++++
 rtl/id_ex_stage_reg.sv | 149 ++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_if.sv
// Decode-to-execute bundle: decoded instruction in, registered EX copy out, plus hazard/flush/hold controls.
interface id_ex_stage_reg_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [6:0]        id_opcode;
  logic [2:0]        id_funct3;
  logic              id_funct7b5;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_MemReadEn;
  logic              id_MemToReg;
  logic              id_MemWriteEn;
  logic              id_ALUSrc;
  logic              id_RegWrite;
  logic              id_BEQ;
  logic              id_BNE;
  logic              id_JALen;
  logic              id_JALRen;
  logic [2:0]        id_ALUop;
  logic              flush_ex;
  logic              hold_ex;

  logic              ex_valid;
  logic [6:0]        ex_opcode;
  logic [2:0]        ex_funct3;
  logic              ex_funct7b5;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [XLEN-1:0]   ex_imm;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_MemReadEn;
  logic              ex_MemToReg;
  logic              ex_MemWriteEn;
  logic              ex_ALUSrc;
  logic              ex_RegWrite;
  logic              ex_BEQ;
  logic              ex_BNE;
  logic              ex_JALen;
  logic              ex_JALRen;
  logic [2:0]        ex_ALUop;
  logic              hazard_stall;
  logic [31:0]       bubble_cnt;
  logic [31:0]       flush_cnt;

  modport master (
    output id_valid, id_opcode, id_funct3, id_funct7b5, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_MemReadEn, id_MemToReg, id_MemWriteEn, id_ALUSrc,
           id_RegWrite, id_BEQ, id_BNE, id_JALen, id_JALRen, id_ALUop, flush_ex, hold_ex,
    input  ex_valid, ex_opcode, ex_funct3, ex_funct7b5, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_MemReadEn, ex_MemToReg, ex_MemWriteEn, ex_ALUSrc,
           ex_RegWrite, ex_BEQ, ex_BNE, ex_JALen, ex_JALRen, ex_ALUop, hazard_stall,
           bubble_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_funct3, id_funct7b5, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_MemReadEn, id_MemToReg, id_MemWriteEn, id_ALUSrc,
           id_RegWrite, id_BEQ, id_BNE, id_JALen, id_JALRen, id_ALUop, flush_ex, hold_ex,
    output ex_valid, ex_opcode, ex_funct3, ex_funct7b5, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_MemReadEn, ex_MemToReg, ex_MemWriteEn, ex_ALUSrc,
           ex_RegWrite, ex_BEQ, ex_BNE, ex_JALen, ex_JALRen, ex_ALUop, hazard_stall,
           bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection; 1-cycle latency, hazard_stall is combinational.
// Backpressure: hold_ex freezes contents, load-use inserts a one-cycle bubble, flush_ex overrides both.
// Optional HAZARD_PERF_CNT_EN builds saturating bubble/flush counters; otherwise they read 0.
module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_stage_reg_if.slave bus
);
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef struct packed {
    logic              valid;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              mem_read_en;
    logic              mem_to_reg;
    logic              mem_write_en;
    logic              alu_src;
    logic              reg_write;
    logic              beq;
    logic              bne;
    logic              jal_en;
    logic              jalr_en;
    logic [2:0]        alu_op;
  } ex_t;

  ex_t  q;
  ex_t  cap;
  ex_t  nxt;
  logic uses_rs1;
  logic uses_rs2;
  logic load_use;

  always_comb begin
    uses_rs1 = !(bus.id_opcode == OP_JAL || bus.id_opcode == OP_LUI);
    uses_rs2 = !bus.id_ALUSrc || bus.id_MemWriteEn || bus.id_BEQ || bus.id_BNE;
    load_use = q.valid && q.mem_read_en && (q.rd != '0) && bus.id_valid &&
               ((uses_rs1 && (bus.id_rs1 == q.rd)) || (uses_rs2 && (bus.id_rs2 == q.rd)));
  end

  assign bus.hazard_stall = load_use && !bus.flush_ex;

  // Controls of an invalid decode slot are zeroed so EX never acts on it.
  always_comb begin
    cap              = '0;
    cap.valid        = bus.id_valid;
    cap.opcode       = bus.id_opcode;
    cap.funct3       = bus.id_funct3;
    cap.funct7b5     = bus.id_funct7b5;
    cap.pc           = bus.id_pc;
    cap.rs1_data     = bus.id_rs1_data;
    cap.rs2_data     = bus.id_rs2_data;
    cap.imm          = bus.id_imm;
    cap.rs1          = bus.id_rs1;
    cap.rs2          = bus.id_rs2;
    cap.rd           = bus.id_rd;
    cap.mem_read_en  = bus.id_valid && bus.id_MemReadEn;
    cap.mem_to_reg   = bus.id_valid && bus.id_MemToReg;
    cap.mem_write_en = bus.id_valid && bus.id_MemWriteEn;
    cap.alu_src      = bus.id_valid && bus.id_ALUSrc;
    cap.reg_write    = bus.id_valid && bus.id_RegWrite;
    cap.beq          = bus.id_valid && bus.id_BEQ;
    cap.bne          = bus.id_valid && bus.id_BNE;
    cap.jal_en       = bus.id_valid && bus.id_JALen;
    cap.jalr_en      = bus.id_valid && bus.id_JALRen;
    cap.alu_op       = bus.id_valid ? bus.id_ALUop : 3'b000;
  end

  always_comb begin
    nxt = q;
    if (bus.flush_ex) begin
      nxt = '0;
    end else if (bus.hold_ex) begin
      nxt = q;
    end else if (load_use) begin
      nxt = '0;
    end else begin
      nxt = cap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

  assign bus.ex_valid      = q.valid;
  assign bus.ex_opcode     = q.opcode;
  assign bus.ex_funct3     = q.funct3;
  assign bus.ex_funct7b5   = q.funct7b5;
  assign bus.ex_pc         = q.pc;
  assign bus.ex_rs1_data   = q.rs1_data;
  assign bus.ex_rs2_data   = q.rs2_data;
  assign bus.ex_imm        = q.imm;
  assign bus.ex_rs1        = q.rs1;
  assign bus.ex_rs2        = q.rs2;
  assign bus.ex_rd         = q.rd;
  assign bus.ex_MemReadEn  = q.mem_read_en;
  assign bus.ex_MemToReg   = q.mem_to_reg;
  assign bus.ex_MemWriteEn = q.mem_write_en;
  assign bus.ex_ALUSrc     = q.alu_src;
  assign bus.ex_RegWrite   = q.reg_write;
  assign bus.ex_BEQ        = q.beq;
  assign bus.ex_BNE        = q.bne;
  assign bus.ex_JALen      = q.jal_en;
  assign bus.ex_JALRen     = q.jalr_en;
  assign bus.ex_ALUop      = q.alu_op;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] bubble_q;
  logic [31:0] flush_q;
  logic        take_bubble;
  logic        take_flush;

  assign take_bubble = !bus.flush_ex && !bus.hold_ex && load_use;
  assign take_flush  = bus.flush_ex && (q.valid || bus.id_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (take_bubble && (bubble_q != 32'hFFFF_FFFF)) bubble_q <= bubble_q + 32'd1;
      if (take_flush && (flush_q != 32'hFFFF_FFFF))   flush_q  <= flush_q + 32'd1;
    end
  end

  assign bus.bubble_cnt = bubble_q;
  assign bus.flush_cnt  = flush_q;
`else
  assign bus.bubble_cnt = 32'h0;
  assign bus.flush_cnt  = 32'h0;
`endif
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed pipeline scenarios then random traffic against an instruction-level model.
module tb_id_ex_stage_reg;
  logic clk;
  logic rst_n;

  id_ex_stage_reg_if #(.XLEN(32), .REG_AW(5)) bif ();

  id_ex_stage_reg #(.XLEN(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] pc;
    logic [31:0] r1d;
    logic [31:0] r2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        mr;
    logic        m2r;
    logic        mw;
    logic        as;
    logic        rw;
    logic        beq;
    logic        bne;
    logic        jal;
    logic        jalr;
    logic [2:0]  aop;
  } rec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  rec_t in;
  rec_t m;
  logic flush;
  logic hold;
  int   bcnt;
  int   fcnt;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] pc);
    rec_t r;
    r     = '0;
    r.v   = 1'b1;
    r.op  = op;
    r.rd  = rd;
    r.rs1 = rs1;
    r.rs2 = rs2;
    r.imm = imm;
    r.pc  = pc;
    r.r1d = 32'h1000 + 32'(rs1);
    r.r2d = 32'h2000 + 32'(rs2);
    return r;
  endfunction

  function automatic rec_t i_add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b, input logic [31:0] pc);
    rec_t r;
    r = mk(7'h33, rd, a, b, 32'h0, pc); r.rw = 1'b1; r.aop = 3'b010;
    return r;
  endfunction

  function automatic rec_t i_addi(input logic [4:0] rd, input logic [4:0] a, input logic [31:0] imm, input logic [31:0] pc);
    rec_t r;
    r = mk(7'h13, rd, a, 5'd0, imm, pc); r.as = 1'b1; r.rw = 1'b1; r.aop = 3'b011;
    return r;
  endfunction

  function automatic rec_t i_lw(input logic [4:0] rd, input logic [4:0] a, input logic [31:0] pc);
    rec_t r;
    r = mk(7'h03, rd, a, 5'd0, 32'h0, pc); r.mr = 1'b1; r.m2r = 1'b1; r.as = 1'b1; r.rw = 1'b1;
    return r;
  endfunction

  function automatic rec_t i_sw(input logic [4:0] src, input logic [4:0] base, input logic [31:0] pc);
    rec_t r;
    r = mk(7'h23, 5'd0, base, src, 32'h0, pc); r.mw = 1'b1; r.as = 1'b1;
    return r;
  endfunction

  // rs1/rs2 fields carry immediate bits for LUI, so they alias rd here on purpose.
  function automatic rec_t i_lui(input logic [4:0] rd, input logic [31:0] pc);
    rec_t r;
    r = mk(7'h37, rd, rd, rd, 32'h5000, pc); r.as = 1'b1; r.rw = 1'b1; r.aop = 3'b100;
    return r;
  endfunction

  function automatic rec_t i_beq(input logic [4:0] a, input logic [4:0] b, input logic [31:0] pc);
    rec_t r;
    r = mk(7'h63, 5'd0, a, b, 32'h10, pc); r.beq = 1'b1; r.aop = 3'b001;
    return r;
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    logic [6:0] ops [8];
    ops = '{7'h37, 7'h6F, 7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    r      = rec_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    r.v    = ($urandom_range(0, 3) != 0);
    r.op   = ops[$urandom_range(0, 7)];
    r.rs1  = 5'($urandom_range(0, 3));
    r.rs2  = 5'($urandom_range(0, 3));
    r.rd   = 5'($urandom_range(0, 3));
    r.mr   = ($urandom_range(0, 1) == 1);
    return r;
  endfunction

  function automatic logic lu_pred(input rec_t e, input rec_t d);
    logic u1;
    logic u2;
    u1 = !(d.op == 7'b1101111 || d.op == 7'b0110111);
    u2 = !d.as || d.mw || d.beq || d.bne;
    return e.v && e.mr && (e.rd != 5'd0) && d.v && ((u1 && d.rs1 == e.rd) || (u2 && d.rs2 == e.rd));
  endfunction

  function automatic logic [31:0] exp_bcnt();
`ifdef HAZARD_PERF_CNT_EN
    return 32'(bcnt);
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_fcnt();
`ifdef HAZARD_PERF_CNT_EN
    return 32'(fcnt);
`else
    return 32'h0;
`endif
  endfunction

  function automatic rec_t observe();
    rec_t r;
    r = '{v: bif.ex_valid, op: bif.ex_opcode, f3: bif.ex_funct3, f7: bif.ex_funct7b5,
          pc: bif.ex_pc, r1d: bif.ex_rs1_data, r2d: bif.ex_rs2_data, imm: bif.ex_imm,
          rs1: bif.ex_rs1, rs2: bif.ex_rs2, rd: bif.ex_rd, mr: bif.ex_MemReadEn,
          m2r: bif.ex_MemToReg, mw: bif.ex_MemWriteEn, as: bif.ex_ALUSrc, rw: bif.ex_RegWrite,
          beq: bif.ex_BEQ, bne: bif.ex_BNE, jal: bif.ex_JALen, jalr: bif.ex_JALRen, aop: bif.ex_ALUop};
    return r;
  endfunction

  task automatic drive();
    bif.id_valid      = in.v;
    bif.id_opcode     = in.op;
    bif.id_funct3     = in.f3;
    bif.id_funct7b5   = in.f7;
    bif.id_pc         = in.pc;
    bif.id_rs1_data   = in.r1d;
    bif.id_rs2_data   = in.r2d;
    bif.id_imm        = in.imm;
    bif.id_rs1        = in.rs1;
    bif.id_rs2        = in.rs2;
    bif.id_rd         = in.rd;
    bif.id_MemReadEn  = in.mr;
    bif.id_MemToReg   = in.m2r;
    bif.id_MemWriteEn = in.mw;
    bif.id_ALUSrc     = in.as;
    bif.id_RegWrite   = in.rw;
    bif.id_BEQ        = in.beq;
    bif.id_BNE        = in.bne;
    bif.id_JALen      = in.jal;
    bif.id_JALRen     = in.jalr;
    bif.id_ALUop      = in.aop;
    bif.flush_ex      = flush;
    bif.hold_ex       = hold;
  endtask

  // Called just after a falling edge: present inputs and compare the combinational stall.
  task automatic present();
    drive();
    #1;
    check("hazard_stall", bif.hazard_stall, lu_pred(m, in) && !flush);
  endtask

  task automatic clock_edge();
    logic lu;
    @(posedge clk);
    lu = lu_pred(m, in);
    if (flush) begin
      if (m.v || in.v) fcnt++;
      m = '0;
    end else if (!hold) begin
      if (lu) begin
        bcnt++;
        m = '0;
      end else begin
        m = in;
        if (!in.v) begin
          {m.mr, m.m2r, m.mw, m.as, m.rw, m.beq, m.bne, m.jal, m.jalr} = '0;
          m.aop = 3'b000;
        end
      end
    end
    @(negedge clk);
    check("ex_state", observe(), m);
    check("bubble_cnt", bif.bubble_cnt, exp_bcnt());
    check("flush_cnt", bif.flush_cnt, exp_fcnt());
  endtask

  task automatic step();
    present();
    clock_edge();
  endtask

  initial begin
    rst_n = 1'b0;
    in    = '0;
    m     = '0;
    flush = 1'b0;
    hold  = 1'b0;
    bcnt  = 0;
    fcnt  = 0;
    drive();
    repeat (2) @(negedge clk);
    check("reset_state", observe(), rec_t'('0));
    check("reset_stall", bif.hazard_stall, 1'b0);
    check("reset_bcnt", bif.bubble_cnt, 32'h0);
    rst_n = 1'b1;

    in = i_addi(5'd5, 5'd1, 32'd12, 32'h100); step();
    check("addi_rd", bif.ex_rd, 5'd5);
    check("addi_imm", bif.ex_imm, 32'd12);
    check("addi_alusrc", bif.ex_ALUSrc, 1'b1);
    check("addi_valid", bif.ex_valid, 1'b1);

    in = i_lw(5'd6, 5'd1, 32'h104); step();
    in = i_add(5'd7, 5'd6, 5'd2, 32'h108); present();
    check("lu_stall", bif.hazard_stall, 1'b1);
    clock_edge();
    check("lu_bubble_valid", bif.ex_valid, 1'b0);
    present();
    check("lu_stall_dropped", bif.hazard_stall, 1'b0);
    clock_edge();
    check("lu_capture_rs1", bif.ex_rs1, 5'd6);
    check("lu_capture_valid", bif.ex_valid, 1'b1);

    in = i_lw(5'd0, 5'd1, 32'h10C); step();
    in = i_add(5'd7, 5'd0, 5'd0, 32'h110); present();
    check("x0_no_stall", bif.hazard_stall, 1'b0);
    clock_edge();
    in = i_lw(5'd6, 5'd1, 32'h114); step();
    in = i_lui(5'd6, 32'h118); present();
    check("lui_no_stall", bif.hazard_stall, 1'b0);
    clock_edge();
    in = i_lw(5'd6, 5'd1, 32'h11C); step();
    in = i_sw(5'd6, 5'd3, 32'h120); present();
    check("sw_stall", bif.hazard_stall, 1'b1);
    clock_edge();

    in = i_lw(5'd6, 5'd1, 32'h124); step();
    in = i_add(5'd7, 5'd6, 5'd2, 32'h128); flush = 1'b1; hold = 1'b1; present();
    check("flush_stall", bif.hazard_stall, 1'b0);
    clock_edge();
    check("flush_valid", bif.ex_valid, 1'b0);
    check("flush_regwrite", bif.ex_RegWrite, 1'b0);
    check("flush_memread", bif.ex_MemReadEn, 1'b0);
    flush = 1'b0; hold = 1'b0;

    in = i_beq(5'd1, 5'd2, 32'h200); step();
    hold = 1'b1;
    in = i_addi(5'd9, 5'd3, 32'd7, 32'h300);
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_beq", bif.ex_BEQ, 1'b1);
      check("hold_pc", bif.ex_pc, 32'h200);
    end
    hold = 1'b0; step();
    check("hold_release_pc", bif.ex_pc, 32'h300);

    for (int k = 0; k < 400; k++) begin
      in    = rand_rec();
      flush = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 5) == 0);
      step();
    end
    flush = 1'b0; hold = 1'b0;

    in = i_lw(5'd6, 5'd1, 32'h400); step();
    in = i_add(5'd7, 5'd6, 5'd2, 32'h404); present();
    check("pre_reset_stall", bif.hazard_stall, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bif.ex_valid, 1'b0);
    check("arst_regwrite", bif.ex_RegWrite, 1'b0);
    check("arst_aluop", bif.ex_ALUop, 3'b000);
    check("arst_stall", bif.hazard_stall, 1'b0);
    check("arst_bcnt", bif.bubble_cnt, 32'h0);
    m = '0; bcnt = 0; fcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
